load_align_unit: RTL and testbench

- Sequential successor to the write-back load-extension logic.
- Accepts one load request at a time from the MEM stage and issues an aligned read on the data bus using a req/gnt plus rvalid handshake.
- Extracts, sign- or zero-extends, or merges (LWL/LWR) the addressed bytes, and returns a registered result with a valid/ready handshake.
- Detects address-error-on-load (AdEL) before any bus access, and supports pipeline flush, including a flush while a bus read is outstanding.

---
 rtl/load_align_unit.sv | 199 +++++++++++++++++++
 tb/tb_load_align_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// Load alignment unit: issues one aligned bus read per load, then extracts,
// extends or merges (LWL/LWR) the addressed bytes into a registered result.
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_rt_old,
  input  logic              flush,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_adel,
  output logic [ADDR_W-1:0] out_badvaddr,
  output logic              busy
);

  // state | meaning
  // IDLE  | ready for a new load request
  // REQ   | bus_req asserted, waiting for bus_gnt
  // WAIT  | read granted, waiting for bus_rvalid
  // DONE  | result (or AdEL) presented until out_ready
  // DRAIN | flushed while a read was outstanding; discard its data

  localparam int BYTES = DATA_W / 8;
  localparam int KW    = $clog2(BYTES);

  localparam logic [OP_W-1:0] LB_OP  = OP_W'(8'b1110_0000);
  localparam logic [OP_W-1:0] LH_OP  = OP_W'(8'b1110_0001);
  localparam logic [OP_W-1:0] LWL_OP = OP_W'(8'b1110_0010);
  localparam logic [OP_W-1:0] LW_OP  = OP_W'(8'b1110_0011);
  localparam logic [OP_W-1:0] LBU_OP = OP_W'(8'b1110_0100);
  localparam logic [OP_W-1:0] LHU_OP = OP_W'(8'b1110_0101);
  localparam logic [OP_W-1:0] LWR_OP = OP_W'(8'b1110_0110);
  localparam logic [OP_W-1:0] LWU_OP = OP_W'(8'b1110_0111);
  localparam logic [OP_W-1:0] LD_OP  = OP_W'(8'b1110_1000);

  localparam bit IS64 = (DATA_W == 64);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rt_q, rt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              adel_q, adel_d;
  logic [ADDR_W-1:0] bad_q, bad_d;
  logic              alive_q;

  // LD/LWU only exist on a 64-bit bus; elsewhere they fall through as raw reads.
  function automatic logic misaligned(input logic [OP_W-1:0] op, input logic [2:0] k);
    logic m;
    m = 1'b0;
    case (op)
      LH_OP, LHU_OP: m = k[0];
      LW_OP:         m = (k[1:0] != 2'b00);
      LWU_OP:        m = IS64 && (k[1:0] != 2'b00);
      LD_OP:         m = IS64 && (k != 3'b000);
      default:       m = 1'b0;
    endcase
    return m;
  endfunction

  logic [2:0] req_k3;
  logic [2:0] k3;
  assign req_k3 = 3'(req_addr[KW-1:0]);
  assign k3     = 3'(addr_q[KW-1:0]);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] word_sh;
  logic [31:0]       w;
  logic [31:0]       r;
  logic [1:0]        j;
  logic [31:0]       lwl;
  logic [31:0]       lwr;
  logic [DATA_W-1:0] result;

  always_comb begin
    shifted = bus_rdata >> {k3, 3'b000};
    word_sh = bus_rdata >> {k3[2], 5'b00000};
    w       = word_sh[31:0];
    r       = rt_q[31:0];
    j       = k3[1:0];
    lwl     = (w << {~j, 3'b000}) | (r & ((32'h1 << {~j, 3'b000}) - 32'h1));
    lwr     = (w >> {j, 3'b000}) | (r & ~(32'hFFFF_FFFF >> {j, 3'b000}));
    result  = bus_rdata;
    case (op_q)
      LB_OP:   result = DATA_W'($signed(shifted[7:0]));
      LBU_OP:  result = DATA_W'(shifted[7:0]);
      LH_OP:   result = DATA_W'($signed(shifted[15:0]));
      LHU_OP:  result = DATA_W'(shifted[15:0]);
      LW_OP:   result = DATA_W'($signed(shifted[31:0]));
      LWU_OP:  result = IS64 ? DATA_W'(shifted[31:0]) : bus_rdata;
      LD_OP:   result = bus_rdata;
      LWL_OP:  result = DATA_W'($signed(lwl));
      LWR_OP:  result = DATA_W'($signed(lwr));
      default: result = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    rt_d    = rt_q;
    data_d  = data_q;
    adel_d  = adel_q;
    bad_d   = bad_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && alive_q && !flush) begin
          op_d   = req_op;
          addr_d = req_addr;
          rt_d   = req_rt_old;
          if (misaligned(req_op, req_k3)) begin
            state_d = S_DONE;
            adel_d  = 1'b1;
            bad_d   = req_addr;
            data_d  = '0;
          end else begin
            state_d = S_REQ;
            adel_d  = 1'b0;
            bad_d   = '0;
          end
        end
      end
      S_REQ: begin
        if (flush)        state_d = S_IDLE;
        else if (bus_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_DRAIN;
        end else if (bus_rvalid) begin
          data_d  = result;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (flush || out_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (bus_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // alive_q keeps req_ready low while reset is held, so every output reads 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      rt_q    <= '0;
      data_q  <= '0;
      adel_q  <= 1'b0;
      bad_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rt_q    <= rt_d;
      data_q  <= data_d;
      adel_q  <= adel_d;
      bad_q   <= bad_d;
      alive_q <= 1'b1;
    end
  end

  assign req_ready    = (state_q == S_IDLE) && alive_q;
  assign bus_req      = (state_q == S_REQ);
  assign bus_addr     = {addr_q[ADDR_W-1:KW], {KW{1'b0}}};
  assign out_valid    = (state_q == S_DONE);
  assign out_data     = data_q;
  assign out_adel     = adel_q;
  assign out_badvaddr = bad_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench: a 32-bit and a 64-bit instance share stimulus; each has its
// own expected-result queue drained by a monitor on out_valid && out_ready.
module tb_load_align_unit;

  localparam logic [7:0] LB  = 8'b1110_0000;
  localparam logic [7:0] LH  = 8'b1110_0001;
  localparam logic [7:0] LWL = 8'b1110_0010;
  localparam logic [7:0] LW  = 8'b1110_0011;
  localparam logic [7:0] LBU = 8'b1110_0100;
  localparam logic [7:0] LHU = 8'b1110_0101;
  localparam logic [7:0] LWR = 8'b1110_0110;
  localparam logic [7:0] LWU = 8'b1110_0111;
  localparam logic [7:0] LD  = 8'b1110_1000;

  logic        clk;
  logic        resetn;
  logic        rv_a, rv_b;
  logic [7:0]  op;
  logic [31:0] addr;
  logic [63:0] rt;
  logic        flush;
  logic        gnt, rvalid;
  logic [63:0] rdata;
  logic        out_ready;

  logic        rdy_a, breq_a, ov_a, adel_a, busy_a;
  logic [31:0] baddr_a, od_a, bad_a;
  logic        rdy_b, breq_b, ov_b, adel_b, busy_b;
  logic [31:0] baddr_b, bad_b;
  logic [63:0] od_b;

  typedef struct packed {
    logic [63:0] d;
    logic        adel;
    logic [31:0] bad;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad = 0;

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .OP_W(8)) dut_a (
    .clk(clk), .resetn(resetn), .req_valid(rv_a), .req_ready(rdy_a), .req_op(op),
    .req_addr(addr), .req_rt_old(rt[31:0]), .flush(flush), .bus_req(breq_a),
    .bus_addr(baddr_a), .bus_gnt(gnt), .bus_rvalid(rvalid), .bus_rdata(rdata[31:0]),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_adel(adel_a),
    .out_badvaddr(bad_a), .busy(busy_a)
  );

  load_align_unit #(.DATA_W(64), .ADDR_W(32), .OP_W(8)) dut_b (
    .clk(clk), .resetn(resetn), .req_valid(rv_b), .req_ready(rdy_b), .req_op(op),
    .req_addr(addr), .req_rt_old(rt), .flush(flush), .bus_req(breq_b),
    .bus_addr(baddr_b), .bus_gnt(gnt), .bus_rvalid(rvalid), .bus_rdata(rdata),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_adel(adel_b),
    .out_badvaddr(bad_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && ov_a && out_ready) begin
      exp_t e;
      if (qa.size() == 0) begin
        chk("a_unexpected_out", 64'(od_a), 64'hDEAD_0000_0000_DEAD);
      end else begin
        e = qa.pop_front();
        chk("a_data", 64'(od_a), {32'h0, e.d[31:0]});
        chk("a_adel", 64'(adel_a), 64'(e.adel));
        if (e.adel) chk("a_badvaddr", 64'(bad_a), 64'(e.bad));
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && ov_b && out_ready) begin
      exp_t e;
      if (qb.size() == 0) begin
        chk("b_unexpected_out", od_b, 64'hDEAD_0000_0000_DEAD);
      end else begin
        e = qb.pop_front();
        chk("b_data", od_b, e.d);
        chk("b_adel", 64'(adel_b), 64'(e.adel));
        if (e.adel) chk("b_badvaddr", 64'(bad_b), 64'(e.bad));
      end
    end
  end

  function automatic logic g_breq(input bit sel);  return sel ? breq_b : breq_a; endfunction
  function automatic logic g_ov(input bit sel);    return sel ? ov_b : ov_a;     endfunction
  function automatic logic g_busy(input bit sel);  return sel ? busy_b : busy_a; endfunction
  function automatic logic [31:0] g_baddr(input bit sel); return sel ? baddr_b : baddr_a; endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input bit sel, input logic [7:0] o, input logic [31:0] a,
                          input logic [63:0] r, input logic [63:0] rd,
                          input logic [63:0] ed, input bit ea);
    exp_t e;
    e.d = ed; e.adel = ea; e.bad = a;
    if (sel) qb.push_back(e); else qa.push_back(e);
    op = o; addr = a; rt = r;
    if (sel) rv_b = 1'b1; else rv_a = 1'b1;
    step();
    rv_a = 1'b0; rv_b = 1'b0;
    if (ea) begin
      chk("adel_no_bus_req", 64'(g_breq(sel)), 64'd0);
      chk("adel_valid_t1", 64'(g_ov(sel)), 64'd1);
    end else begin
      chk("bus_req_t1", 64'(g_breq(sel)), 64'd1);
      chk("bus_addr", 64'(g_baddr(sel)), 64'(a & (sel ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC)));
      gnt = 1'b1;
      step();
      gnt = 1'b0;
      chk("bus_req_drop", 64'(g_breq(sel)), 64'd0);
      rvalid = 1'b1; rdata = rd;
      step();
      rvalid = 1'b0;
      chk("valid_r1", 64'(g_ov(sel)), 64'd1);
    end
    step();
    chk("valid_one_cycle", 64'(g_ov(sel)), 64'd0);
    chk("idle_after", 64'(g_busy(sel)), 64'd0);
  endtask

  initial begin
    resetn = 1'b1; rv_a = 1'b0; rv_b = 1'b0; op = '0; addr = '0; rt = '0;
    flush = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; out_ready = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("rst_req_ready", 64'(rdy_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_bus_req", 64'(breq_a), 64'd0);
    chk("rst_out_valid", 64'(ov_b), 64'd0);
    chk("rst_out_data", od_b, 64'd0);
    step(); step();
    #2 resetn = 1'b1;
    step(); step();
    chk("idle_req_ready", 64'(rdy_a), 64'd1);

    // 32-bit instance
    run_load(0, LB,  32'h1003, 0, 64'h80AA_BBCC, 64'hFFFF_FF80, 0);
    run_load(0, LBU, 32'h1003, 0, 64'h80AA_BBCC, 64'h0000_0080, 0);
    run_load(0, LH,  32'h2001, 0, 0,             64'h0,         1);
    run_load(0, LHU, 32'h2002, 0, 64'h8001_1234, 64'h0000_8001, 0);
    run_load(0, LWL, 32'h0011, 64'hAABB_CCDD, 64'h4433_2211, 64'h2211_CCDD, 0);
    run_load(0, LWR, 32'h0011, 64'hAABB_CCDD, 64'h4433_2211, 64'hAA44_3322, 0);
    run_load(0, LWL, 32'h0013, 64'hAABB_CCDD, 64'h4433_2211, 64'h4433_2211, 0);
    run_load(0, LWR, 32'h0010, 64'hAABB_CCDD, 64'h4433_2211, 64'h4433_2211, 0);
    run_load(0, LW,  32'h0102, 0, 0,             64'h0,         1);
    run_load(0, LD,  32'h0003, 0, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 0);

    // 64-bit instance
    run_load(1, LW,  32'h0004, 0, 64'h8000_0001_0000_0002, 64'hFFFF_FFFF_8000_0001, 0);
    run_load(1, LWU, 32'h0004, 0, 64'h8000_0001_0000_0002, 64'h0000_0000_8000_0001, 0);
    run_load(1, LD,  32'h0004, 0, 0, 64'h0, 1);
    run_load(1, LD,  32'h0008, 0, 64'h8000_0001_0000_0002, 64'h8000_0001_0000_0002, 0);
    run_load(1, LB,  32'h0007, 0, 64'h80AA_BBCC_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 0);
    run_load(1, LWL, 32'h0015, 64'hAABB_CCDD, 64'h4433_2211_0000_0000, 64'h0000_0000_2211_CCDD, 0);
    run_load(1, LWL, 32'h0003, 64'hAABB_CCDD, 64'h0000_0000_8033_2211, 64'hFFFF_FFFF_8033_2211, 0);

    // delayed grant and back-pressured result
    begin
      exp_t e;
      e.d = 64'h1234_5678; e.adel = 1'b0; e.bad = 32'h0;
      qa.push_back(e);
      out_ready = 1'b0;
      op = LW; addr = 32'h0100; rv_a = 1'b1;
      step();
      rv_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk("req_held", 64'(breq_a), 64'd1);
        chk("addr_held", 64'(baddr_a), 64'h100);
        step();
      end
      gnt = 1'b1; step(); gnt = 1'b0;
      rvalid = 1'b1; rdata = 64'h1234_5678; step(); rvalid = 1'b0;
      op = LB; addr = 32'h0200; rv_a = 1'b1;
      for (int i = 0; i < 4; i++) begin
        chk("bp_valid", 64'(ov_a), 64'd1);
        chk("bp_data_stable", 64'(od_a), 64'h1234_5678);
        chk("bp_no_accept", 64'(rdy_a), 64'd0);
        step();
      end
      rv_a = 1'b0; out_ready = 1'b1;
      step();
      chk("bp_idle", 64'(busy_a), 64'd0);
      step();
      chk("bp_no_second", 64'(busy_a), 64'd0);
    end

    // flush in IDLE, REQ, DONE
    op = LW; addr = 32'h0300; rv_a = 1'b1; flush = 1'b1;
    step();
    rv_a = 1'b0; flush = 1'b0;
    chk("flush_idle_ignored", 64'(busy_a), 64'd0);
    rv_a = 1'b1; step(); rv_a = 1'b0;
    flush = 1'b1; gnt = 1'b1; step(); flush = 1'b0; gnt = 1'b0;
    chk("flush_req_busreq", 64'(breq_a), 64'd0);
    chk("flush_req_idle", 64'(busy_a), 64'd0);
    out_ready = 1'b0;
    op = LH; addr = 32'h3001; rv_a = 1'b1; step(); rv_a = 1'b0;
    step();
    chk("done_held", 64'(ov_a), 64'd1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_done_valid", 64'(ov_a), 64'd0);
    out_ready = 1'b1;

    // flush in WAIT drains the outstanding read
    op = LW; addr = 32'h0400; rv_a = 1'b1; step(); rv_a = 1'b0;
    gnt = 1'b1; step(); gnt = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    chk("drain_busy", 64'(busy_a), 64'd1);
    step();
    chk("drain_wait", 64'(busy_a), 64'd1);
    rvalid = 1'b1; rdata = 64'h5555_AAAA; step(); rvalid = 1'b0;
    chk("drain_idle", 64'(busy_a), 64'd0);
    chk("drain_no_valid", 64'(ov_a), 64'd0);
    step();
    chk("drain_no_valid2", 64'(ov_a), 64'd0);

    // async reset mid-REQ
    op = LW; addr = 32'h0500; rv_a = 1'b1; step(); rv_a = 1'b0;
    chk("rst_pre_req", 64'(breq_a), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_busreq", 64'(breq_a), 64'd0);
    chk("rst_async_busy", 64'(busy_a), 64'd0);
    chk("rst_async_ready", 64'(rdy_a), 64'd0);
    step();
    resetn = 1'b1;
    step(); step();
    chk("post_rst_ready", 64'(rdy_a), 64'd1);
    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
